// File: rtl/pf_issue_queue_pkg.sv
// Shared prefetcher constants (address width, queue/filter/inflight defaults) and small helpers.
// Imported by the issue queue, its CAM FIFO and the ISB.
package pf_issue_queue_pkg;
    localparam int PF_AW           = 16;
    localparam int PF_DEPTH        = 4;
    localparam int PF_HIST         = 4;
    localparam int PF_MAX_INFLIGHT = 2;
    localparam int PF_DROP_W       = 8;

    typedef logic [PF_AW-1:0] pf_addr_t;

    function automatic logic [PF_DROP_W-1:0] sat_inc(input logic [PF_DROP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/pf_cam_fifo.sv
// Prefetch FIFO with per-entry valid bits, parallel address compare and address invalidation.
// Push/pop take effect at the edge; caller guarantees no push when full and no pop when empty.
module pf_cam_fifo
    import pf_issue_queue_pkg::*;
#(
    parameter int DEPTH = PF_DEPTH
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  pf_addr_t                 i_push_addr,
    input  logic                     i_pop,
    input  logic                     i_inv_v,
    input  pf_addr_t                 i_inv_addr,
    input  logic                     i_keep_head,
    input  pf_addr_t                 i_cmp_addr,
    output logic                     o_cmp_hit,
    output logic                     o_head_v,
    output pf_addr_t                 o_head_addr,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);

    pf_addr_t         r_addr [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // A head already presented to memory must survive a matching demand.
            for (int i = 0; i < DEPTH; i++) begin
                if (i_inv_v && r_valid[i] && (r_addr[i] == i_inv_addr) &&
                    !(i_keep_head && (r_head == PW'(i))))
                    r_valid[i] <= 1'b0;
            end
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (i_push) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= i_push_addr;
                r_tail          <= r_tail + 1'b1;
            end
            if (i_push && !i_pop)
                r_count <= r_count + 1'b1;
            else if (!i_push && i_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_comb begin
        o_cmp_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == i_cmp_addr)) o_cmp_hit = 1'b1;
        end
    end

    assign o_head_v    = (r_count != '0) && r_valid[r_head];
    assign o_head_addr = r_addr[r_head];
    assign o_count     = r_count;
endmodule

// File: rtl/pf_issue_queue.sv
// Filters prefetch candidates (queue/history/demand), queues them and issues to memory under an inflight cap.
// Issue no earlier than 1 cycle after pf_v; request held stable until mem_req_rdy; full queue drops and counts.
module pf_issue_queue
    import pf_issue_queue_pkg::*;
#(
    parameter int DEPTH        = PF_DEPTH,
    parameter int HIST         = PF_HIST,
    parameter int MAX_INFLIGHT = PF_MAX_INFLIGHT
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pf_v,
    input  logic [PF_AW-1:0]     pf_addr,
    input  logic                 dm_v,
    input  logic [PF_AW-1:0]     dm_addr,
    output logic                 mem_req_v,
    output logic [PF_AW-1:0]     mem_req_addr,
    input  logic                 mem_req_rdy,
    input  logic                 mem_done,
    output logic [PF_DROP_W-1:0] drop_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = $clog2(HIST);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    pf_addr_t             r_hist_addr [HIST];
    logic [HIST-1:0]      r_hist_v;
    logic [HW-1:0]        r_hist_ptr;
    logic [IW-1:0]        r_inflight;
    logic [PF_DROP_W-1:0] r_drop_cnt;

    logic          w_q_hit, w_hist_hit, w_filt, w_full;
    logic          w_push, w_drop, w_req, w_accept, w_skip, w_pop, w_inflt_dec;
    logic          w_head_v;
    pf_addr_t      w_head_addr;
    logic [CW-1:0] w_count;

    pf_cam_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_addr (pf_addr),
        .i_pop       (w_pop),
        .i_inv_v     (dm_v),
        .i_inv_addr  (dm_addr),
        .i_keep_head (w_req),
        .i_cmp_addr  (pf_addr),
        .o_cmp_hit   (w_q_hit),
        .o_head_v    (w_head_v),
        .o_head_addr (w_head_addr),
        .o_count     (w_count)
    );

    always_comb begin
        w_hist_hit = 1'b0;
        for (int i = 0; i < HIST; i++) begin
            if (r_hist_v[i] && (r_hist_addr[i] == pf_addr)) w_hist_hit = 1'b1;
        end
    end

    // Filtering takes priority over the full check: a duplicate is never counted as a drop.
    assign w_filt      = w_q_hit || w_hist_hit || (dm_v && (dm_addr == pf_addr));
    assign w_full      = (w_count == CW'(DEPTH));
    assign w_push      = pf_v && !w_filt && !w_full;
    assign w_drop      = pf_v && !w_filt && w_full;
    assign w_req       = w_head_v && (r_inflight < IW'(MAX_INFLIGHT));
    assign w_accept    = w_req && mem_req_rdy;
    assign w_skip      = (w_count != '0) && !w_head_v;
    assign w_pop       = w_accept || w_skip;
    assign w_inflt_dec = mem_done && (r_inflight != '0);

    assign mem_req_v    = w_req;
    assign mem_req_addr = w_req ? w_head_addr : '0;
    assign drop_cnt     = r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST; i++) r_hist_addr[i] <= '0;
            r_hist_v   <= '0;
            r_hist_ptr <= '0;
        end else if (w_accept) begin
            r_hist_addr[r_hist_ptr] <= w_head_addr;
            r_hist_v[r_hist_ptr]    <= 1'b1;
            r_hist_ptr <= (r_hist_ptr == HW'(HIST - 1)) ? '0 : r_hist_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            case ({w_accept, w_inflt_dec})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: ;
            endcase
            if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end
endmodule

// File: tb/tb_pf_issue_queue.sv
// Randomized and directed bench for pf_issue_queue against a queue-based reference model with a scoreboard.
module tb_pf_issue_queue;
    localparam int DEPTH = 4;
    localparam int HIST  = 4;
    localparam int MAXI  = 2;

    logic        clk;
    logic        rst_n;
    logic        pf_v;
    logic [15:0] pf_addr;
    logic        dm_v;
    logic [15:0] dm_addr;
    logic        mem_req_v;
    logic [15:0] mem_req_addr;
    logic        mem_req_rdy;
    logic        mem_done;
    logic [7:0]  drop_cnt;

    pf_issue_queue #(.DEPTH(DEPTH), .HIST(HIST), .MAX_INFLIGHT(MAXI)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pf_v         (pf_v),
        .pf_addr      (pf_addr),
        .dm_v         (dm_v),
        .dm_addr      (dm_addr),
        .mem_req_v    (mem_req_v),
        .mem_req_addr (mem_req_addr),
        .mem_req_rdy  (mem_req_rdy),
        .mem_done     (mem_done),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] qa[$];
    bit          qv[$];
    logic [15:0] hist[$];
    logic [15:0] exp_q[$];
    int          minfl;
    int          mdrop;
    bit          m_exp_v;
    logic [15:0] m_exp_addr;
    int          m_exp_drop;
    bit          chk_en = 0;
    bit          saw418 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        qa.delete(); qv.delete(); hist.delete(); exp_q.delete();
        minfl = 0; mdrop = 0;
        m_exp_v = 0; m_exp_addr = '0; m_exp_drop = 0;
    endtask

    task automatic model_step();
        bit hv, req, acc, filt, full, push, drop;
        int pre;
        hv   = (qa.size() > 0) && qv[0];
        req  = hv && (minfl < MAXI);
        acc  = req && mem_req_rdy;
        m_exp_v    = req;
        m_exp_addr = req ? qa[0] : 16'h0;
        m_exp_drop = mdrop;
        filt = 0;
        if (pf_v) begin
            foreach (qa[i]) if (qv[i] && qa[i] == pf_addr) filt = 1;
            foreach (hist[i]) if (hist[i] == pf_addr) filt = 1;
            if (dm_v && dm_addr == pf_addr) filt = 1;
        end
        full = (qa.size() == DEPTH);
        push = pf_v && !filt && !full;
        drop = pf_v && !filt && full;
        if (dm_v)
            foreach (qa[i]) if (qa[i] == dm_addr && !(i == 0 && req)) qv[i] = 0;
        if (acc) begin
            exp_q.push_back(qa[0]);
            hist.push_back(qa[0]);
            if (hist.size() > HIST) hist.delete(0);
            qa.delete(0); qv.delete(0);
        end else if (qa.size() > 0 && !hv) begin
            qa.delete(0); qv.delete(0);
        end
        pre = minfl;
        if (acc) minfl++;
        if (mem_done && pre > 0) minfl--;
        if (push) begin qa.push_back(pf_addr); qv.push_back(1'b1); end
        if (drop && mdrop < 255) mdrop++;
    endtask

    task automatic cyc(input bit pv, input logic [15:0] pa, input bit dv,
                       input logic [15:0] da, input bit rd, input bit dn);
        @(posedge clk); #1;
        pf_v = pv; pf_addr = pa; dm_v = dv; dm_addr = da;
        mem_req_rdy = rd; mem_done = dn;
        model_step();
    endtask

    task automatic expect_out(input string nm, input bit v, input logic [15:0] a);
        @(negedge clk);
        chk({nm, "_v"}, {31'd0, mem_req_v}, {31'd0, v});
        if (v) chk({nm, "_addr"}, {16'd0, mem_req_addr}, {16'd0, a});
    endtask

    task automatic do_reset();
        chk_en = 0;
        rst_n = 1'b0;
        pf_v = 0; pf_addr = '0; dm_v = 0; dm_addr = '0; mem_req_rdy = 0; mem_done = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1;
    endtask

    // Monitor / scoreboard
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("req_v", {31'd0, mem_req_v}, {31'd0, m_exp_v});
                if (m_exp_v) chk("req_addr", {16'd0, mem_req_addr}, {16'd0, m_exp_addr});
                chk("drop_cnt", {24'd0, drop_cnt}, m_exp_drop);
                if (mem_req_v && mem_req_rdy) begin
                    if (mem_req_addr == 16'h0418) saw418 = 1;
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_accept", {16'd0, mem_req_addr}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_accept_addr", {16'd0, mem_req_addr}, {16'd0, e});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        do_reset();
        expect_out("reset", 0, 16'h0);
        chk("reset_drop", {24'd0, drop_cnt}, 32'd0);

        // Back-to-back issue up to the inflight cap, third waits for mem_done
        cyc(1, 16'h0100, 0, 0, 1, 0);
        cyc(1, 16'h0104, 0, 0, 1, 0); expect_out("s1_first", 1, 16'h0100);
        cyc(1, 16'h0108, 0, 0, 1, 0); expect_out("s1_second", 1, 16'h0104);
        cyc(0, 0, 0, 0, 1, 0);        expect_out("s1_blocked", 0, 16'h0);
        cyc(0, 0, 0, 0, 1, 1);        expect_out("s1_done_edge", 0, 16'h0);
        cyc(0, 0, 0, 0, 1, 0);        expect_out("s1_after_done", 1, 16'h0108);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);

        // History filter
        cyc(1, 16'h0200, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);        expect_out("s2_issue", 1, 16'h0200);
        cyc(1, 16'h0200, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);        expect_out("s2_filtered", 0, 16'h0);
        chk("s2_drop", {24'd0, drop_cnt}, 32'd0);
        cyc(0, 0, 0, 0, 1, 1);

        // Fill with inflight at cap: 4 queued, 2 dropped
        cyc(1, 16'h0400, 0, 0, 1, 0);
        cyc(1, 16'h0404, 0, 0, 1, 0);
        cyc(1, 16'h0410, 0, 0, 1, 0);
        for (int i = 1; i < 6; i++) cyc(1, 16'h0410 + 16'(4 * i), 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);        expect_out("s3_full", 0, 16'h0);
        chk("s3_drop", {24'd0, drop_cnt}, 32'd2);

        // Demand invalidation of a non-head entry; locked head survives
        cyc(0, 0, 1, 16'h0418, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 16'h0410, 0, 0); expect_out("s4_lock", 1, 16'h0410);
        cyc(0, 0, 0, 0, 0, 0);        expect_out("s4_hold", 1, 16'h0410);
        cyc(0, 0, 0, 0, 1, 0);        expect_out("s4_accept", 1, 16'h0410);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 1);
        chk("s4_inval_never_issued", {31'd0, saw418}, 32'd0);

        // Reset in the middle of a stalled handshake
        cyc(1, 16'h0500, 0, 0, 0, 0);
        cyc(1, 16'h0504, 0, 0, 0, 0); expect_out("s5_pending", 1, 16'h0500);
        #2;
        chk_en = 0;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_req_v", {31'd0, mem_req_v}, 32'd0);
        chk("s5_rst_req_addr", {16'd0, mem_req_addr}, 32'd0);
        chk("s5_rst_drop", {24'd0, drop_cnt}, 32'd0);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
        expect_out("s5_empty", 0, 16'h0);
        chk("s5_drop_after", {24'd0, drop_cnt}, 32'd0);

        // Random traffic over a small address pool to provoke filter hits
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 1) == 1), 16'h0600 + 16'(4 * $urandom_range(0, 11)),
                ($urandom_range(0, 4) == 0), 16'h0600 + 16'(4 * $urandom_range(0, 11)),
                ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, 1, 1);

        // Saturating drop counter
        for (int i = 0; i < 260; i++) cyc(1, 16'h7000 + 16'(4 * i), 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat_drop", {24'd0, drop_cnt}, 32'd255);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pf_issue_queue.md
PF_ISSUE_QUEUE -- requirements
Module: pf_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of 2).
REQ-002 SHALL have parameter HIST, default 4, recently-issued address filter entries.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 2, outstanding prefetches allowed.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pf_v  input  1  prefetch candidate valid, from the ISB prefetch_v.
REQ-007 SHALL have port pf_addr  input  16  prefetch candidate address, from the ISB prefetch_addr.
REQ-008 SHALL have port dm_v  input  1  demand access valid.
REQ-009 SHALL have port dm_addr  input  16  demand access address.
REQ-010 SHALL have port mem_req_v  output  1  prefetch request valid to memory.
REQ-011 SHALL have port mem_req_addr  output  16  prefetch request address.
REQ-012 SHALL have port mem_req_rdy  input  1  memory accepts request.
REQ-013 SHALL have port mem_done  input  1  one prefetch completed (pulse).
REQ-014 SHALL have port drop_cnt  output  8  saturating count of dropped candidates.

Function
REQ-015 SHALL enqueue pf_addr at posedge when pf_v=1 and no filter hit and queue count<DEPTH (pre-edge count).
REQ-016 SHALL filter (drop silently, no drop_cnt) when pf_addr equals any valid queued entry, any valid history entry, or dm_addr with dm_v=1 in the same cycle.
REQ-017 SHALL drop a non-filtered candidate when the queue is full, even if a dequeue occurs that cycle, and increment drop_cnt, saturating at 255.
REQ-018 SHALL, on dm_v=1, clear the valid bit of every queued entry whose address equals dm_addr, except the locked head (REQ-020).
REQ-019 SHALL pop an invalidated head entry in one cycle without asserting mem_req_v.
REQ-020 SHALL drive mem_req_v=1 when the head entry is valid and inflight<MAX_INFLIGHT; once asserted, the head is locked and mem_req_v/mem_req_addr remain stable until mem_req_rdy=1.
REQ-021 SHALL pop the head, insert its address into history (round-robin replacement), and increment inflight on mem_req_v && mem_req_rdy.
REQ-022 SHALL decrement inflight on mem_done; simultaneous accept and mem_done leave inflight unchanged; mem_done at inflight=0 is ignored.
REQ-023 SHALL present a candidate on mem_req_v no earlier than the cycle after its pf_v (1-cycle minimum latency).
REQ-024 SHALL wrap head/tail pointers modulo DEPTH and allow enqueue and dequeue in the same cycle when not full.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously clear queue valid bits, history valid bits, head/tail/count, inflight and drop_cnt; mem_req_v=0, mem_req_addr=0.
REQ-026 SHALL discard an in-progress handshake on reset; no request is retained across reset.

Structure
REQ-027 SHALL place DEPTH/HIST/MAX_INFLIGHT defaults and the 16-bit address width constant in the shared prefetcher package, also used by isb.
REQ-028 SHALL implement the queue as sub-module pf_cam_fifo (FIFO with per-entry valid bits and parallel address compare); history filter and issue logic stay in pf_issue_queue.

Verification
REQ-029 SHALL cover: pf_v with 0x0100, 0x0104 on consecutive cycles, rdy=1 -> requests 0x0100 then 0x0104, inflight reaches 2, third candidate waits until mem_done.
REQ-030 SHALL cover: 0x0200 issued, then pf_v 0x0200 again -> filtered by history, no request, drop_cnt unchanged.
REQ-031 SHALL cover: rdy=0, inflight=2, 6 distinct candidates -> 4 queued, drop_cnt=2.
REQ-032 SHALL cover: 0x0300 queued at non-head slot, dm_v with dm_addr=0x0300 -> entry never issued; same address on locked head with rdy=0 -> still issued.
REQ-033 SHALL cover: rst_n low while mem_req_v=1, rdy=0 -> mem_req_v=0 immediately, queue empty, drop_cnt=0 after release.
